upower_lsu: RTL and testbench

Load/store unit for the uPower datapath, directly downstream of the ALU. It takes the ALU's effective address for D- and DS-format memory opcodes and runs a valid/ready transaction on a 64-bit data-memory port. It returns load data, sign- or zero-extended, for the register writeback path. For update-form stores it also returns the effective address to rs.

---
 rtl/upower_lsu_pkg.sv | 84 ++++++++
 rtl/lsu_lane_align.sv | 63 ++++++
 rtl/upower_lsu.sv | 253 +++++++++++++++++++++++++
 tb/tb_upower_lsu.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/upower_lsu_pkg.sv
// Purpose: shared opcodes, access sizes, FSM states and opcode decode for the uPower LSU.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Build option: LSU_MISALIGN_SPLIT_EN (consumed by upower_lsu, not by this package).
package upower_lsu_pkg;

  // Primary opcodes of the D- and DS-format memory instructions.
  localparam logic [5:0] LW0   = 6'd32;
  localparam logic [5:0] LB0   = 6'd34;
  localparam logic [5:0] SW    = 6'd36;
  localparam logic [5:0] SWU   = 6'd37;
  localparam logic [5:0] SB    = 6'd38;
  localparam logic [5:0] LHW   = 6'd40;
  localparam logic [5:0] LHWA  = 6'd42;
  localparam logic [5:0] SHW   = 6'd44;
  localparam logic [5:0] DS_LD = 6'd58;
  localparam logic [5:0] DS_ST = 6'd62;

  typedef enum logic [1:0] {
    B = 2'd0,
    H = 2'd1,
    W = 2'd2,
    D = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    REQ2  = 3'd3,
    WAIT2 = 3'd4,
    DONE  = 3'd5
  } state_e;

  typedef struct packed {
    logic  vld;    // recognised memory operation
    logic  store;
    logic  upd;    // update form: EA is written back to rs
    logic  sext;   // sign-extend load data
    size_e size;
  } dec_t;

  function automatic dec_t decode(input logic [5:0] op, input logic [1:0] xods);
    dec_t d;
    d      = '0;
    d.size = B;
    case (op)
      LW0:   begin d.vld = 1'b1; d.size = W; end
      LB0:   begin d.vld = 1'b1; d.size = B; end
      LHW:   begin d.vld = 1'b1; d.size = H; end
      LHWA:  begin d.vld = 1'b1; d.size = H; d.sext = 1'b1; end
      SW:    begin d.vld = 1'b1; d.size = W; d.store = 1'b1; end
      SB:    begin d.vld = 1'b1; d.size = B; d.store = 1'b1; end
      SHW:   begin d.vld = 1'b1; d.size = H; d.store = 1'b1; end
      SWU:   begin d.vld = 1'b1; d.size = W; d.store = 1'b1; d.upd = 1'b1; end
      DS_LD: begin
        if (xods == 2'd0) begin
          d.vld = 1'b1; d.size = D;
        end else if (xods == 2'd2) begin
          d.vld = 1'b1; d.size = W; d.sext = 1'b1;
        end
      end
      DS_ST: begin
        if (xods == 2'd0) begin
          d.vld = 1'b1; d.size = D; d.store = 1'b1;
        end else if (xods == 2'd1) begin
          d.vld = 1'b1; d.size = D; d.store = 1'b1; d.upd = 1'b1;
        end
      end
      default: ;
    endcase
    return d;
  endfunction

  function automatic logic [3:0] size_bytes(input size_e s);
    case (s)
      B:       return 4'd1;
      H:       return 4'd2;
      W:       return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Purpose: little-endian lane steering: byte enables, store-data shift, load extract/merge/extend.
// Latency: combinational, zero cycles.
// Backpressure: none (pure function of its inputs).
// Ports: i_size/i_ea_lo/i_sext describe the access; i_st_data is raw store data;
//        i_ld_lo/i_ld_hi are the lower/upper doubleword reads; o_be0/o_wdata0 drive the
//        first request, o_be1/o_wdata1 the second (crossing) request; o_ld_data is extended.
module lsu_lane_align
  import upower_lsu_pkg::*;
(
  input  size_e       i_size,
  input  logic [2:0]  i_ea_lo,
  input  logic        i_sext,
  input  logic [63:0] i_st_data,
  input  logic [63:0] i_ld_lo,
  input  logic [63:0] i_ld_hi,
  output logic [7:0]  o_be0,
  output logic [7:0]  o_be1,
  output logic [63:0] o_wdata0,
  output logic [63:0] o_wdata1,
  output logic [63:0] o_ld_data
);

  logic [5:0]   w_shift;
  logic [7:0]   w_mask8;
  logic [15:0]  w_mask16;
  logic [63:0]  w_st_m;
  logic [127:0] w_st_sh;
  logic [127:0] w_ld_cat;
  logic [63:0]  w_ld_raw;

  always_comb begin
    w_shift = {i_ea_lo, 3'b000};

    case (i_size)
      B:       begin w_mask8 = 8'h01; w_st_m = {56'd0, i_st_data[7:0]};  end
      H:       begin w_mask8 = 8'h03; w_st_m = {48'd0, i_st_data[15:0]}; end
      W:       begin w_mask8 = 8'h0F; w_st_m = {32'd0, i_st_data[31:0]}; end
      default: begin w_mask8 = 8'hFF; w_st_m = i_st_data;                end
    endcase

    // A 16-lane window spans two doublewords; the upper half is the
    // remainder of an access that crosses the doubleword boundary.
    w_mask16 = {8'h00, w_mask8} << i_ea_lo;
    o_be0    = w_mask16[7:0];
    o_be1    = w_mask16[15:8];

    w_st_sh  = {64'd0, w_st_m} << w_shift;
    o_wdata0 = w_st_sh[63:0];
    o_wdata1 = w_st_sh[127:64];

    // Byte 0 of the datum is brought to lane 0 across the merged pair.
    w_ld_cat = {i_ld_hi, i_ld_lo};
    w_ld_raw = 64'(w_ld_cat >> w_shift);

    case (i_size)
      B:       o_ld_data = {{56{i_sext & w_ld_raw[7]}},  w_ld_raw[7:0]};
      H:       o_ld_data = {{48{i_sext & w_ld_raw[15]}}, w_ld_raw[15:0]};
      W:       o_ld_data = {{32{i_sext & w_ld_raw[31]}}, w_ld_raw[31:0]};
      default: o_ld_data = w_ld_raw;
    endcase
  end

endmodule

// File: rtl/upower_lsu.sv
// Purpose: uPower load/store unit: ALU EA in, valid/ready 64-bit memory port out, load writeback.
// Latency: accept in cycle 0, request from cycle 1, best-case wb_valid in cycle 3.
// Backpressure: req_ready only in IDLE; request held stable until mem_req_ready.
// Build option: LSU_MISALIGN_SPLIT_EN splits doubleword-crossing accesses into two requests;
//   without it a crossing access pulses err_misalign and touches no memory.
// Ports: req_* / opcode / xods / ALU_result / rt_value / rt / rs from issue; mem_* memory port;
//   wb_* load writeback; upd_* update-form base write; err_* one-cycle fault pulses.
module upower_lsu
  import upower_lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  opcode,
  input  logic [1:0]  xods,
  input  logic [63:0] ALU_result,
  input  logic [63:0] rt_value,
  input  logic [4:0]  rt,
  input  logic [4:0]  rs,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_be,
  input  logic        mem_rsp_valid,
  input  logic [63:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [63:0] wb_data,
  output logic        upd_valid,
  output logic [4:0]  upd_ra,
  output logic [63:0] upd_data,
  output logic        err_misalign,
  output logic        err_op
);

  state_e      r_state;
  state_e      w_next;

  logic [63:0] r_ea;
  logic [63:0] r_st_data;
  logic [4:0]  r_rt;
  logic [4:0]  r_rs;
  size_e       r_size;
  logic        r_sext;
  logic        r_store;
  logic        r_upd;

  logic        r_wb_valid;
  logic [4:0]  r_wb_rd;
  logic [63:0] r_wb_data;
  logic        r_upd_valid;
  logic [4:0]  r_upd_ra;
  logic [63:0] r_upd_data;
  logic        r_err_misalign;
  logic        r_err_op;

  dec_t        w_dec;
  logic        w_accept;
  logic        w_cross_in;
  logic        w_done_mem;   // final memory response of a transaction arrives this cycle
  logic [63:0] w_dw_addr;
  logic [7:0]  w_be0;
  logic [7:0]  w_be1;
  logic [63:0] w_wdata0;
  logic [63:0] w_wdata1;
  logic [63:0] w_ld_lo;
  logic [63:0] w_ld_hi;
  logic [63:0] w_ld_data;

`ifdef LSU_MISALIGN_SPLIT_EN
  logic        r_cross;
  logic [63:0] r_rdata0;      // lower-doubleword read held until the second response

  assign w_ld_lo = (r_state == WAIT2) ? r_rdata0 : mem_rdata;
  assign w_ld_hi = (r_state == WAIT2) ? mem_rdata : 64'd0;
`else
  // Crossing accesses never reach memory here, so the upper-lane outputs carry nothing.
  logic        w_unused_hi;

  assign w_ld_lo     = mem_rdata;
  assign w_ld_hi     = 64'd0;
  assign w_unused_hi = ^{w_be1, w_wdata1};
`endif

  assign w_dec      = decode(opcode, xods);
  assign w_accept   = req_valid & req_ready;
  assign w_cross_in = ({1'b0, ALU_result[2:0]} + size_bytes(w_dec.size)) > 4'd8;
  assign w_dw_addr  = {r_ea[63:3], 3'b000};

  lsu_lane_align u_align (
    .i_size    (r_size),
    .i_ea_lo   (r_ea[2:0]),
    .i_sext    (r_sext),
    .i_st_data (r_st_data),
    .i_ld_lo   (w_ld_lo),
    .i_ld_hi   (w_ld_hi),
    .o_be0     (w_be0),
    .o_be1     (w_be1),
    .o_wdata0  (w_wdata0),
    .o_wdata1  (w_wdata1),
    .o_ld_data (w_ld_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = 64'd0;
    mem_wdata     = 64'd0;
    mem_be        = 8'd0;
    w_done_mem    = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (!w_dec.vld) begin
            w_next = DONE;
          end else if (w_cross_in) begin
`ifdef LSU_MISALIGN_SPLIT_EN
            w_next = REQ;
`else
            w_next = DONE;
`endif
          end else begin
            w_next = REQ;
          end
        end
      end
      REQ: begin
        mem_req_valid = 1'b1;
        mem_we        = r_store;
        mem_addr      = w_dw_addr;
        mem_wdata     = w_wdata0;
        mem_be        = w_be0;
        if (mem_req_ready) w_next = WAIT;
      end
      WAIT: begin
        if (mem_rsp_valid) begin
`ifdef LSU_MISALIGN_SPLIT_EN
          if (r_cross) begin
            w_next = REQ2;
          end else begin
            w_next     = DONE;
            w_done_mem = 1'b1;
          end
`else
          w_next     = DONE;
          w_done_mem = 1'b1;
`endif
        end
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      REQ2: begin
        mem_req_valid = 1'b1;
        mem_we        = r_store;
        mem_addr      = w_dw_addr + 64'd8;
        mem_wdata     = w_wdata1;
        mem_be        = w_be1;
        if (mem_req_ready) w_next = WAIT2;
      end
      WAIT2: begin
        if (mem_rsp_valid) begin
          w_next     = DONE;
          w_done_mem = 1'b1;
        end
      end
`endif
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ea           <= 64'd0;
      r_st_data      <= 64'd0;
      r_rt           <= 5'd0;
      r_rs           <= 5'd0;
      r_size         <= B;
      r_sext         <= 1'b0;
      r_store        <= 1'b0;
      r_upd          <= 1'b0;
      r_wb_valid     <= 1'b0;
      r_wb_rd        <= 5'd0;
      r_wb_data      <= 64'd0;
      r_upd_valid    <= 1'b0;
      r_upd_ra       <= 5'd0;
      r_upd_data     <= 64'd0;
      r_err_misalign <= 1'b0;
      r_err_op       <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
      r_cross        <= 1'b0;
      r_rdata0       <= 64'd0;
`endif
    end else begin
      // Pulses are registered on the transition into DONE, so they are high exactly in DONE.
      r_wb_valid     <= 1'b0;
      r_upd_valid    <= 1'b0;
      r_err_misalign <= 1'b0;
      r_err_op       <= 1'b0;
      if (w_accept) begin
        r_ea      <= ALU_result;
        r_st_data <= rt_value;
        r_rt      <= rt;
        r_rs      <= rs;
        r_size    <= w_dec.size;
        r_sext    <= w_dec.sext;
        r_store   <= w_dec.store;
        r_upd     <= w_dec.upd;
        r_err_op  <= ~w_dec.vld;
`ifdef LSU_MISALIGN_SPLIT_EN
        r_cross   <= w_cross_in;
`else
        r_err_misalign <= w_dec.vld & w_cross_in;
`endif
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      if (r_state == WAIT && mem_rsp_valid) r_rdata0 <= mem_rdata;
`endif
      if (w_done_mem) begin
        if (!r_store) begin
          r_wb_valid <= 1'b1;
          r_wb_rd    <= r_rt;
          r_wb_data  <= w_ld_data;
        end
        if (r_upd) begin
          r_upd_valid <= 1'b1;
          r_upd_ra    <= r_rs;
          r_upd_data  <= r_ea;
        end
      end
    end
  end

  assign wb_valid     = r_wb_valid;
  assign wb_rd        = r_wb_rd;
  assign wb_data      = r_wb_data;
  assign upd_valid    = r_upd_valid;
  assign upd_ra       = r_upd_ra;
  assign upd_data     = r_upd_data;
  assign err_misalign = r_err_misalign;
  assign err_op       = r_err_op;

endmodule

// File: tb/tb_upower_lsu.sv
// Purpose: directed self-checking bench for upower_lsu (loads, stores, stalls, faults, reset).
// Latency: follows the unit's cycle-exact handshake; every step is a fixed cycle count.
// Backpressure: bench drives mem_req_ready/mem_rsp_valid by hand to create stalls.
module tb_upower_lsu;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  opcode;
  logic [1:0]  xods;
  logic [63:0] ALU_result;
  logic [63:0] rt_value;
  logic [4:0]  rt;
  logic [4:0]  rs;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_be;
  logic        mem_rsp_valid;
  logic [63:0] mem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        upd_valid;
  logic [4:0]  upd_ra;
  logic [63:0] upd_data;
  logic        err_misalign;
  logic        err_op;

  int checks = 0;
  int errors = 0;

  upower_lsu dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .opcode        (opcode),
    .xods          (xods),
    .ALU_result    (ALU_result),
    .rt_value      (rt_value),
    .rt            (rt),
    .rs            (rs),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_be        (mem_be),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rdata     (mem_rdata),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .upd_valid     (upd_valid),
    .upd_ra        (upd_ra),
    .upd_data      (upd_data),
    .err_misalign  (err_misalign),
    .err_op        (err_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  // Advance one clock; inputs are changed and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one operation for exactly one cycle (unit is idle, so it is accepted).
  task automatic issue(input logic [5:0] op, input logic [1:0] xo, input logic [63:0] ea,
                       input logic [63:0] wd, input logic [4:0] t, input logic [4:0] s);
    req_valid  = 1'b1;
    opcode     = op;
    xods       = xo;
    ALU_result = ea;
    rt_value   = wd;
    rt         = t;
    rs         = s;
    step();
    req_valid  = 1'b0;
  endtask

  // Grant the pending request, then return one response carrying rd.
  task automatic serve(input logic [63:0] rd);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rdata     = rd;
    step();
    mem_rsp_valid = 1'b0;
    mem_rdata     = 64'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    checks++; if ({mem_req_valid, mem_we, mem_be, mem_addr, mem_wdata} !== 137'd0) begin errors++; $display("FAIL reset_mem got v=%b we=%b be=%h a=%h d=%h want all 0", mem_req_valid, mem_we, mem_be, mem_addr, mem_wdata); end
    checks++; if ({wb_valid, wb_rd, wb_data, upd_valid, upd_ra, upd_data, err_misalign, err_op} !== 144'd0) begin errors++; $display("FAIL reset_wb_upd_err got wbv=%b wbd=%h updv=%b updd=%h em=%b eo=%b want all 0", wb_valid, wb_data, upd_valid, upd_data, err_misalign, err_op); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_lwz();
    issue(6'd32, 2'd0, 64'h1004, 64'd0, 5'd7, 5'd3);
    checks++; if (mem_req_valid !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL lwz_req got v=%b we=%b want v=1 we=0", mem_req_valid, mem_we); end
    checks++; if (mem_addr !== 64'h1000) begin errors++; $display("FAIL lwz_addr got %h want %h", mem_addr, 64'h1000); end
    checks++; if (mem_be !== 8'hF0) begin errors++; $display("FAIL lwz_be got %h want f0", mem_be); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL lwz_busy got req_ready=%b want 0", req_ready); end
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL lwz_req_drop got %b want 0", mem_req_valid); end
    mem_rsp_valid = 1'b1;
    mem_rdata     = 64'h8877665544332211;
    step();
    mem_rsp_valid = 1'b0;
    mem_rdata     = 64'd0;
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL lwz_wb_valid got %b want 1", wb_valid); end
    checks++; if (wb_data !== 64'h0000000088776655) begin errors++; $display("FAIL lwz_wb_data got %h want %h", wb_data, 64'h0000000088776655); end
    checks++; if (wb_rd !== 5'd7) begin errors++; $display("FAIL lwz_wb_rd got %0d want 7", wb_rd); end
    step();
    checks++; if (wb_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL lwz_after_done got wb_valid=%b req_ready=%b want 0/1", wb_valid, req_ready); end
    checks++; if (wb_data !== 64'h0000000088776655) begin errors++; $display("FAIL lwz_wb_hold got %h want %h", wb_data, 64'h0000000088776655); end
  endtask

  // Issued in the cycle right after the previous DONE to cover back-to-back acceptance.
  task automatic test_lha();
    issue(6'd42, 2'd0, 64'h2006, 64'd0, 5'd4, 5'd0);
    checks++; if (mem_addr !== 64'h2000 || mem_be !== 8'hC0) begin errors++; $display("FAIL lha_req got a=%h be=%h want 2000/c0", mem_addr, mem_be); end
    serve(64'h80FF000000000000);
    checks++; if (wb_valid !== 1'b1 || wb_data !== 64'hFFFFFFFFFFFF80FF) begin errors++; $display("FAIL lha_wb got v=%b d=%h want 1/%h", wb_valid, wb_data, 64'hFFFFFFFFFFFF80FF); end
    checks++; if (wb_rd !== 5'd4) begin errors++; $display("FAIL lha_wb_rd got %0d want 4", wb_rd); end
    step();
  endtask

  task automatic test_stdu();
    issue(6'd62, 2'd1, 64'h3000, 64'h0123456789ABCDEF, 5'd1, 5'd9);
    checks++; if (mem_we !== 1'b1 || mem_be !== 8'hFF || mem_addr !== 64'h3000) begin errors++; $display("FAIL stdu_req got we=%b be=%h a=%h want 1/ff/3000", mem_we, mem_be, mem_addr); end
    checks++; if (mem_wdata !== 64'h0123456789ABCDEF) begin errors++; $display("FAIL stdu_wdata got %h want %h", mem_wdata, 64'h0123456789ABCDEF); end
    serve(64'hDEADDEADDEADDEAD);
    checks++; if (upd_valid !== 1'b1 || upd_data !== 64'h3000 || upd_ra !== 5'd9) begin errors++; $display("FAIL stdu_upd got v=%b d=%h ra=%0d want 1/3000/9", upd_valid, upd_data, upd_ra); end
    checks++; if (wb_valid !== 1'b0 || wb_data !== 64'hFFFFFFFFFFFF80FF) begin errors++; $display("FAIL stdu_no_wb got v=%b d=%h want 0/%h", wb_valid, wb_data, 64'hFFFFFFFFFFFF80FF); end
    step();
    checks++; if (upd_valid !== 1'b0 || upd_data !== 64'h3000) begin errors++; $display("FAIL stdu_upd_hold got v=%b d=%h want 0/3000", upd_valid, upd_data); end
  endtask

  task automatic test_stb();
    issue(6'd38, 2'd0, 64'h6005, 64'h1122334455667788, 5'd0, 5'd0);
    checks++; if (mem_be !== 8'h20 || mem_addr !== 64'h6000 || mem_we !== 1'b1) begin errors++; $display("FAIL stb_req got be=%h a=%h we=%b want 20/6000/1", mem_be, mem_addr, mem_we); end
    checks++; if (mem_wdata !== 64'h0000880000000000) begin errors++; $display("FAIL stb_wdata got %h want %h", mem_wdata, 64'h0000880000000000); end
    serve(64'd0);
    checks++; if (wb_valid !== 1'b0 || upd_valid !== 1'b0) begin errors++; $display("FAIL stb_no_pulse got wb=%b upd=%b want 0/0", wb_valid, upd_valid); end
    step();
  endtask

  task automatic test_stall();
    issue(6'd34, 2'd0, 64'h5003, 64'd0, 5'd12, 5'd0);
    for (int i = 0; i < 5; i++) begin
      checks++; if ({mem_req_valid, req_ready, mem_addr, mem_be} !== {1'b1, 1'b0, 64'h5000, 8'h08}) begin errors++; $display("FAIL stall_hold%0d got v=%b rdy=%b a=%h be=%h want 1/0/5000/08", i, mem_req_valid, req_ready, mem_addr, mem_be); end
      // A stray response while the request is pending must be ignored.
      mem_rsp_valid = (i == 2);
      mem_rdata     = (i == 2) ? 64'hFFFFFFFFFFFFFFFF : 64'd0;
      step();
    end
    mem_rsp_valid = 1'b0;
    mem_rdata     = 64'd0;
    checks++; if (mem_req_valid !== 1'b1 || wb_valid !== 1'b0) begin errors++; $display("FAIL stall_still_req got v=%b wb=%b want 1/0", mem_req_valid, wb_valid); end
    serve(64'h00000000AB000000);
    checks++; if (wb_valid !== 1'b1 || wb_data !== 64'hAB || wb_rd !== 5'd12) begin errors++; $display("FAIL stall_lbz_wb got v=%b d=%h rd=%0d want 1/ab/12", wb_valid, wb_data, wb_rd); end
    step();
  endtask

  task automatic test_misalign();
`ifdef LSU_MISALIGN_SPLIT_EN
    issue(6'd36, 2'd0, 64'h4006, 64'h00000000DDCCBBAA, 5'd0, 5'd2);
    checks++; if (mem_addr !== 64'h4000 || mem_be !== 8'hC0 || mem_wdata !== 64'hBBAA000000000000) begin errors++; $display("FAIL split_st_req1 got a=%h be=%h d=%h want 4000/c0/bbaa000000000000", mem_addr, mem_be, mem_wdata); end
    serve(64'd0);
    checks++; if (mem_req_valid !== 1'b1 || mem_addr !== 64'h4008 || mem_be !== 8'h03 || mem_wdata !== 64'hDDCC) begin errors++; $display("FAIL split_st_req2 got v=%b a=%h be=%h d=%h want 1/4008/03/ddcc", mem_req_valid, mem_addr, mem_be, mem_wdata); end
    serve(64'd0);
    checks++; if (wb_valid !== 1'b0 || upd_valid !== 1'b0 || err_misalign !== 1'b0) begin errors++; $display("FAIL split_st_done got wb=%b upd=%b em=%b want 0/0/0", wb_valid, upd_valid, err_misalign); end
    step();
    issue(6'd58, 2'd2, 64'h7006, 64'd0, 5'd5, 5'd0);
    checks++; if (mem_addr !== 64'h7000 || mem_be !== 8'hC0) begin errors++; $display("FAIL split_ld_req1 got a=%h be=%h want 7000/c0", mem_addr, mem_be); end
    serve(64'h2211000000000000);
    checks++; if (mem_addr !== 64'h7008 || mem_be !== 8'h03) begin errors++; $display("FAIL split_ld_req2 got a=%h be=%h want 7008/03", mem_addr, mem_be); end
    serve(64'h000000000000C433);
    checks++; if (wb_valid !== 1'b1 || wb_data !== 64'hFFFFFFFFC4332211 || wb_rd !== 5'd5) begin errors++; $display("FAIL split_ld_wb got v=%b d=%h rd=%0d want 1/ffffffffc4332211/5", wb_valid, wb_data, wb_rd); end
    step();
`else
    issue(6'd36, 2'd0, 64'h4006, 64'h00000000DDCCBBAA, 5'd0, 5'd2);
    checks++; if (err_misalign !== 1'b1) begin errors++; $display("FAIL misalign_pulse got %b want 1", err_misalign); end
    checks++; if (mem_req_valid !== 1'b0 || wb_valid !== 1'b0 || upd_valid !== 1'b0 || err_op !== 1'b0) begin errors++; $display("FAIL misalign_quiet got v=%b wb=%b upd=%b eo=%b want 0/0/0/0", mem_req_valid, wb_valid, upd_valid, err_op); end
    step();
    checks++; if (err_misalign !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL misalign_end got em=%b rdy=%b want 0/1", err_misalign, req_ready); end
    issue(6'd58, 2'd0, 64'h9001, 64'd0, 5'd6, 5'd0);
    checks++; if (err_misalign !== 1'b1 || mem_req_valid !== 1'b0 || wb_valid !== 1'b0) begin errors++; $display("FAIL misalign_ld got em=%b v=%b wb=%b want 1/0/0", err_misalign, mem_req_valid, wb_valid); end
    step();
`endif
  endtask

  task automatic test_err_op();
    issue(6'd14, 2'd0, 64'h1000, 64'd0, 5'd3, 5'd3);
    checks++; if (err_op !== 1'b1 || mem_req_valid !== 1'b0 || err_misalign !== 1'b0) begin errors++; $display("FAIL errop14 got eo=%b v=%b em=%b want 1/0/0", err_op, mem_req_valid, err_misalign); end
    step();
    checks++; if (err_op !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL errop14_end got eo=%b rdy=%b want 0/1", err_op, req_ready); end
    issue(6'd58, 2'd1, 64'h1000, 64'd0, 5'd3, 5'd3);
    checks++; if (err_op !== 1'b1 || mem_req_valid !== 1'b0 || wb_valid !== 1'b0) begin errors++; $display("FAIL errop58x1 got eo=%b v=%b wb=%b want 1/0/0", err_op, mem_req_valid, wb_valid); end
    step();
  endtask

  task automatic test_reset_mid();
    issue(6'd58, 2'd0, 64'h8000, 64'd0, 5'd9, 5'd0);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    // Unit is waiting; the response arrives at the same edge reset is applied.
    rst_n         = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rdata     = 64'h1234567812345678;
    step();
    rst_n         = 1'b1;
    mem_rsp_valid = 1'b0;
    mem_rdata     = 64'd0;
    checks++; if (req_ready !== 1'b1 || mem_req_valid !== 1'b0) begin errors++; $display("FAIL rstmid_idle got rdy=%b v=%b want 1/0", req_ready, mem_req_valid); end
    checks++; if ({wb_valid, wb_rd, wb_data, upd_valid, upd_ra, upd_data, err_misalign, err_op} !== 144'd0) begin errors++; $display("FAIL rstmid_outs got wbv=%b wbd=%h updv=%b updd=%h want all 0", wb_valid, wb_data, upd_valid, upd_data); end
    step();
    checks++; if (wb_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_dropped got wb=%b rdy=%b want 0/1", wb_valid, req_ready); end
  endtask

  initial begin
    rst_n         = 1'b0;
    req_valid     = 1'b0;
    opcode        = 6'd0;
    xods          = 2'd0;
    ALU_result    = 64'd0;
    rt_value      = 64'd0;
    rt            = 5'd0;
    rs            = 5'd0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rdata     = 64'd0;
    #1;
    test_reset();
    test_lwz();
    test_lha();
    test_stdu();
    test_stb();
    test_stall();
    test_misalign();
    test_err_op();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
